// File: rtl/mips_bus_arbiter.sv
// Two-master arbiter for the CPU memory bus: instruction fetch (m0) and load/store (m1).
// Serialises transactions onto one downstream port with one-cycle read latency.
module mips_bus_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int ROUND_ROBIN = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   s_address,
    output logic                s_read,
    output logic                s_write,
    output logic [DATA_W-1:0]   s_writedata,
    output logic [DATA_W/8-1:0] s_byteenable,
    input  logic                s_waitrequest,
    input  logic [DATA_W-1:0]   s_readdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_grant_q, last_grant_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;
    logic                rdv0_q, rdv0_d;
    logic                rdv1_q, rdv1_d;

    logic                req0_s, req1_s, grant_s;
    logic                own_read_s, own_write_s, own_req_s, issue_s;

    assign req0_s      = m0_read | m0_write;
    assign req1_s      = m1_read | m1_write;
    assign own_read_s  = owner_q ? m1_read  : m0_read;
    assign own_write_s = owner_q ? m1_write : m0_write;
    assign own_req_s   = own_read_s | own_write_s;
    assign issue_s     = (state_q == ISSUE);

    // Arbitration: on contention, round-robin flips away from the last winner.
    always_comb begin
        grant_s = 1'b0;
        if (req0_s && req1_s) begin
            grant_s = (ROUND_ROBIN != 0) ? ~last_grant_q : 1'b0;
        end else if (req1_s) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Downstream port follows the owner only while in ISSUE; write wins over read.
    assign s_address    = owner_q ? m1_address    : m0_address;
    assign s_writedata  = owner_q ? m1_writedata  : m0_writedata;
    assign s_byteenable = owner_q ? m1_byteenable : m0_byteenable;
    assign s_write      = issue_s & own_write_s;
    assign s_read       = issue_s & own_read_s & ~own_write_s;

    assign m0_waitrequest = ~(issue_s & ~owner_q & own_req_s & ~s_waitrequest);
    assign m1_waitrequest = ~(issue_s &  owner_q & own_req_s & ~s_waitrequest);

    assign m0_readdata      = rdata0_q;
    assign m1_readdata      = rdata1_q;
    assign m0_readdatavalid = rdv0_q;
    assign m1_readdatavalid = rdv1_q;

    // Next-state logic for the IDLE/ISSUE/RESP sequencer and the response registers.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        rdv0_d       = 1'b0;
        rdv1_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0_s || req1_s) begin
                    owner_d      = grant_s;
                    last_grant_d = grant_s;
                    state_d      = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (!own_req_s) begin
                    state_d = IDLE;
                end else if (!s_waitrequest) begin
                    state_d = own_write_s ? IDLE : RESP;
                end else begin
                    state_d = ISSUE;
                end
            end
            RESP: begin
                state_d = IDLE;
                if (owner_q) begin
                    rdata1_d = s_readdata;
                    rdv1_d   = 1'b1;
                end else begin
                    rdata0_d = s_readdata;
                    rdv0_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset favours m0 on the first contention.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            rdata0_q     <= {DATA_W{1'b0}};
            rdata1_q     <= {DATA_W{1'b0}};
            rdv0_q       <= 1'b0;
            rdv1_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            rdv0_q       <= rdv0_d;
            rdv1_q       <= rdv1_d;
        end
    end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed bench for mips_bus_arbiter: a round-robin instance plus a fixed-priority
// instance sharing the master inputs, each backed by a small one-cycle-latency memory.
module tb_mips_bus_arbiter;

    localparam logic [31:0] A0 = 32'hBFC00000;
    localparam logic [31:0] A1 = 32'hBFC00030;
    localparam logic [31:0] AW = 32'hBFC0002C;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] m0_address = 32'h0, m1_address = 32'h0;
    logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
    logic [31:0] m0_writedata = 32'h0, m1_writedata = 32'h0;
    logic [3:0]  m0_byteenable = 4'h0, m1_byteenable = 4'h0;
    logic        s_wait = 1'b0;

    logic        m0_waitrequest, m0_readdatavalid, m1_waitrequest, m1_readdatavalid;
    logic [31:0] m0_readdata, m1_readdata, s_address, s_writedata, s_rdata;
    logic        s_read, s_write;
    logic [3:0]  s_byteenable;

    logic        fp_m0_waitrequest, fp_m0_readdatavalid, fp_m1_waitrequest, fp_m1_readdatavalid;
    logic [31:0] fp_m0_readdata, fp_m1_readdata, fp_s_address, fp_s_writedata, fp_rdata;
    logic        fp_s_read, fp_s_write;
    logic [3:0]  fp_s_byteenable;

    logic [31:0] mem [0:15];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .ROUND_ROBIN(1)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .s_address(s_address), .s_read(s_read), .s_write(s_write), .s_writedata(s_writedata),
        .s_byteenable(s_byteenable), .s_waitrequest(s_wait), .s_readdata(s_rdata)
    );

    mips_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .ROUND_ROBIN(0)) dut_fp (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(fp_m0_waitrequest), .m0_readdata(fp_m0_readdata), .m0_readdatavalid(fp_m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(fp_m1_waitrequest), .m1_readdata(fp_m1_readdata), .m1_readdatavalid(fp_m1_readdatavalid),
        .s_address(fp_s_address), .s_read(fp_s_read), .s_write(fp_s_write), .s_writedata(fp_s_writedata),
        .s_byteenable(fp_s_byteenable), .s_waitrequest(s_wait), .s_readdata(fp_rdata)
    );

    // Memory seen by the round-robin instance; contents restored on reset.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'(i);
            mem[0]  <= 32'h3C08BFC0;
            mem[12] <= 32'h00000008;
            s_rdata <= 32'h0;
        end else begin
            if (s_read && !s_wait) s_rdata <= mem[s_address[5:2]];
            if (s_write && !s_wait) mem[s_address[5:2]] <= s_writedata;
        end
    end

    // Read-only view of the same memory for the fixed-priority instance.
    always @(posedge clk) begin
        if (reset) fp_rdata <= 32'h0;
        else if (fp_s_read && !s_wait) fp_rdata <= mem[fp_s_address[5:2]];
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        cyc();
        reset = 1'b1;
        m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
        s_wait = 1'b0;
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; m0_read = 1'b1; m0_address = A0;
        cyc(); cyc();
        @(negedge clk);
        checks++; if (s_read !== 1'b0) begin errors++; $display("FAIL rst_s_read got %b exp 0", s_read); end
        checks++; if (s_write !== 1'b0) begin errors++; $display("FAIL rst_s_write got %b exp 0", s_write); end
        checks++; if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin errors++; $display("FAIL rst_rdv got %b%b exp 00", m0_readdatavalid, m1_readdatavalid); end
        checks++; if (m0_readdata !== 32'h0 || m1_readdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h %h exp 0 0", m0_readdata, m1_readdata); end
        checks++; if (m0_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_m0_wait got %b exp 1", m0_waitrequest); end
        cyc();
        reset = 1'b0; m0_read = 1'b0;
    endtask

    task automatic test_read;
        do_reset();
        m0_read = 1'b1; m0_address = A0;
        @(negedge clk);
        checks++; if (s_read !== 1'b0 || m0_waitrequest !== 1'b1) begin errors++; $display("FAIL rd_c0 got s_read=%b wait=%b exp 0 1", s_read, m0_waitrequest); end
        cyc(); @(negedge clk);
        checks++; if (s_read !== 1'b1 || s_address !== A0) begin errors++; $display("FAIL rd_c1_strobe got %b %h exp 1 %h", s_read, s_address, A0); end
        checks++; if (m0_waitrequest !== 1'b0) begin errors++; $display("FAIL rd_c1_wait got %b exp 0", m0_waitrequest); end
        cyc(); m0_read = 1'b0; @(negedge clk);
        checks++; if (s_read !== 1'b0 || m0_readdatavalid !== 1'b0) begin errors++; $display("FAIL rd_c2 got s_read=%b rdv=%b exp 0 0", s_read, m0_readdatavalid); end
        cyc(); @(negedge clk);
        checks++; if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'h3C08BFC0) begin errors++; $display("FAIL rd_c3_data got %b %h exp 1 3c08bfc0", m0_readdatavalid, m0_readdata); end
        checks++; if (m1_readdatavalid !== 1'b0 || m1_readdata !== 32'h0) begin errors++; $display("FAIL rd_c3_m1 got %b %h exp 0 0", m1_readdatavalid, m1_readdata); end
        cyc(); @(negedge clk);
        checks++; if (m0_readdatavalid !== 1'b0 || m0_readdata !== 32'h3C08BFC0) begin errors++; $display("FAIL rd_c4_hold got %b %h exp 0 3c08bfc0", m0_readdatavalid, m0_readdata); end
    endtask

    task automatic test_write;
        do_reset();
        m1_write = 1'b1; m1_read = 1'b1; m1_address = AW; m1_writedata = 32'hF0000000; m1_byteenable = 4'b1111;
        @(negedge clk);
        checks++; if (s_write !== 1'b0 || m1_waitrequest !== 1'b1) begin errors++; $display("FAIL wr_c0 got s_write=%b wait=%b exp 0 1", s_write, m1_waitrequest); end
        cyc(); @(negedge clk);
        checks++; if (s_write !== 1'b1 || s_read !== 1'b0) begin errors++; $display("FAIL wr_c1_strobe got w=%b r=%b exp 1 0", s_write, s_read); end
        checks++; if (s_address !== AW || s_writedata !== 32'hF0000000 || s_byteenable !== 4'hF) begin errors++; $display("FAIL wr_c1_fields got %h %h %h exp %h f0000000 f", s_address, s_writedata, s_byteenable, AW); end
        checks++; if (m1_waitrequest !== 1'b0) begin errors++; $display("FAIL wr_c1_wait got %b exp 0", m1_waitrequest); end
        checks++; if (fp_s_write !== 1'b1 || fp_s_writedata !== 32'hF0000000 || fp_s_byteenable !== 4'hF) begin errors++; $display("FAIL wr_fp_fields got %b %h %h exp 1 f0000000 f", fp_s_write, fp_s_writedata, fp_s_byteenable); end
        cyc(); m1_write = 1'b0; m1_read = 1'b0; @(negedge clk);
        checks++; if (s_write !== 1'b0 || m1_waitrequest !== 1'b1) begin errors++; $display("FAIL wr_c2 got s_write=%b wait=%b exp 0 1", s_write, m1_waitrequest); end
        checks++; if (mem[11] !== 32'hF0000000) begin errors++; $display("FAIL wr_mem11 got %h exp f0000000", mem[11]); end
    endtask

    task automatic test_contention;
        logic [31:0] exp_m0, exp_m1, exp_fp0;
        logic        e_rd, e_rdv0, e_rdv1, e_fprdv;
        do_reset();
        exp_m0 = 32'h0; exp_m1 = 32'h0; exp_fp0 = 32'h0;
        m0_read = 1'b1; m0_address = A0; m1_read = 1'b1; m1_address = A1;
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) cyc();
            @(negedge clk);
            e_rd   = (k % 3 == 1);
            e_rdv0 = (k % 6 == 3);
            e_rdv1 = (k > 0) && (k % 6 == 0);
            e_fprdv = (k > 0) && (k % 3 == 0);
            if (e_rdv0) exp_m0 = 32'h3C08BFC0;
            if (e_rdv1) exp_m1 = 32'h00000008;
            if (e_fprdv) exp_fp0 = 32'h3C08BFC0;
            checks++; if (s_read !== e_rd) begin errors++; $display("FAIL rr_s_read k=%0d got %b exp %b", k, s_read, e_rd); end
            if (e_rd) begin
                checks++; if (s_address !== ((k % 6 == 1) ? A0 : A1)) begin errors++; $display("FAIL rr_grant k=%0d got %h exp %h", k, s_address, (k % 6 == 1) ? A0 : A1); end
                checks++; if (fp_s_address !== A0) begin errors++; $display("FAIL fp_grant k=%0d got %h exp %h", k, fp_s_address, A0); end
            end
            checks++; if (m0_readdatavalid !== e_rdv0 || m1_readdatavalid !== e_rdv1) begin errors++; $display("FAIL rr_rdv k=%0d got %b%b exp %b%b", k, m0_readdatavalid, m1_readdatavalid, e_rdv0, e_rdv1); end
            checks++; if (m0_readdata !== exp_m0 || m1_readdata !== exp_m1) begin errors++; $display("FAIL rr_rdata k=%0d got %h %h exp %h %h", k, m0_readdata, m1_readdata, exp_m0, exp_m1); end
            checks++; if (fp_s_read !== e_rd || fp_s_write !== 1'b0) begin errors++; $display("FAIL fp_strobe k=%0d got r=%b w=%b exp %b 0", k, fp_s_read, fp_s_write, e_rd); end
            checks++; if (fp_m1_waitrequest !== 1'b1 || fp_m0_waitrequest !== !e_rd) begin errors++; $display("FAIL fp_wait k=%0d got m0=%b m1=%b exp %b 1", k, fp_m0_waitrequest, fp_m1_waitrequest, !e_rd); end
            checks++; if (fp_m0_readdatavalid !== e_fprdv || fp_m1_readdatavalid !== 1'b0) begin errors++; $display("FAIL fp_rdv k=%0d got %b%b exp %b0", k, fp_m0_readdatavalid, fp_m1_readdatavalid, e_fprdv); end
            checks++; if (fp_m0_readdata !== exp_fp0 || fp_m1_readdata !== 32'h0) begin errors++; $display("FAIL fp_rdata k=%0d got %h %h exp %h 0", k, fp_m0_readdata, fp_m1_readdata, exp_fp0); end
        end
        cyc();
        m0_read = 1'b0; m1_read = 1'b0;
    endtask

    task automatic test_stall;
        do_reset();
        s_wait = 1'b1; m1_read = 1'b1; m1_address = A1;
        for (int k = 1; k <= 5; k++) begin
            cyc(); @(negedge clk);
            checks++; if (s_read !== 1'b1 || s_address !== A1 || m1_waitrequest !== 1'b1) begin errors++; $display("FAIL st_hold k=%0d got %b %h %b exp 1 %h 1", k, s_read, s_address, m1_waitrequest, A1); end
        end
        cyc(); s_wait = 1'b0; @(negedge clk);
        checks++; if (s_read !== 1'b1 || s_address !== A1 || m1_waitrequest !== 1'b0) begin errors++; $display("FAIL st_accept got %b %h %b exp 1 %h 0", s_read, s_address, m1_waitrequest, A1); end
        cyc(); m1_read = 1'b0; @(negedge clk);
        checks++; if (s_read !== 1'b0 || m1_readdatavalid !== 1'b0) begin errors++; $display("FAIL st_resp got %b %b exp 0 0", s_read, m1_readdatavalid); end
        cyc(); @(negedge clk);
        checks++; if (m1_readdatavalid !== 1'b1 || m1_readdata !== 32'h00000008) begin errors++; $display("FAIL st_data got %b %h exp 1 00000008", m1_readdatavalid, m1_readdata); end
        checks++; if (m0_readdatavalid !== 1'b0 || m0_readdata !== 32'h0) begin errors++; $display("FAIL st_m0_untouched got %b %h exp 0 0", m0_readdatavalid, m0_readdata); end
    endtask

    task automatic test_drop;
        do_reset();
        s_wait = 1'b1; m0_read = 1'b1; m0_address = A0;
        cyc(); @(negedge clk);
        checks++; if (s_read !== 1'b1) begin errors++; $display("FAIL drop_c1 got %b exp 1", s_read); end
        cyc(); m0_read = 1'b0; s_wait = 1'b0; @(negedge clk);
        checks++; if (s_read !== 1'b0) begin errors++; $display("FAIL drop_c2 got %b exp 0", s_read); end
        cyc(); @(negedge clk);
        checks++; if (s_read !== 1'b0 || m0_readdatavalid !== 1'b0) begin errors++; $display("FAIL drop_c3 got %b %b exp 0 0", s_read, m0_readdatavalid); end
        cyc(); @(negedge clk);
        checks++; if (m0_readdatavalid !== 1'b0) begin errors++; $display("FAIL drop_c4 got %b exp 0", m0_readdatavalid); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        m0_read = 1'b1; m0_address = A0;
        cyc(); @(negedge clk);
        checks++; if (s_read !== 1'b1) begin errors++; $display("FAIL rm_c1 got %b exp 1", s_read); end
        cyc(); m0_read = 1'b0; reset = 1'b1; @(negedge clk);
        checks++; if (s_read !== 1'b0) begin errors++; $display("FAIL rm_c2 got %b exp 0", s_read); end
        cyc(); reset = 1'b0; m0_read = 1'b1; m1_read = 1'b1; m1_address = A1; @(negedge clk);
        checks++; if (m0_readdatavalid !== 1'b0 || s_read !== 1'b0 || m0_readdata !== 32'h0) begin errors++; $display("FAIL rm_c3 got rdv=%b s_read=%b data=%h exp 0 0 0", m0_readdatavalid, s_read, m0_readdata); end
        cyc(); @(negedge clk);
        checks++; if (s_read !== 1'b1 || s_address !== A0) begin errors++; $display("FAIL rm_grant got %b %h exp 1 %h", s_read, s_address, A0); end
        checks++; if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1) begin errors++; $display("FAIL rm_wait got %b %b exp 0 1", m0_waitrequest, m1_waitrequest); end
        cyc(); m0_read = 1'b0; m1_read = 1'b0;
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_contention();
        test_stall();
        test_drop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_bus_arbiter.md
Name: mips_bus_arbiter

Overview:
- Two-master arbiter that shares the single CPU-side memory bus between the instruction-fetch port (m0) and the load/store port (m1).
- Sits between the CPU core's fetch/data units and the external bus exposed by mips_cpu_bus.
- The downstream bus has a fixed read latency of one cycle after acceptance and uses waitrequest back-pressure.
- The block serialises transactions, applies round-robin priority, and routes read data back to the owner.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- ROUND_ROBIN, 1, 1 = alternate priority on contention; 0 = fixed priority with m0 always winning.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous active-high reset.
- mN_address  input  ADDR_W  master N byte address (N = 0,1; all mN_ ports are duplicated per master).
- mN_read  input  1  master N read request.
- mN_write  input  1  master N write request.
- mN_writedata  input  DATA_W  master N write data.
- mN_byteenable  input  DATA_W/8  master N byte lanes.
- mN_waitrequest  output  1  high = request not yet accepted.
- mN_readdata  output  DATA_W  registered read data for master N.
- mN_readdatavalid  output  1  one-cycle pulse when mN_readdata is new.
- s_address  output  ADDR_W  downstream address.
- s_read  output  1  downstream read strobe.
- s_write  output  1  downstream write strobe.
- s_writedata  output  DATA_W  downstream write data.
- s_byteenable  output  DATA_W/8  downstream byte lanes.
- s_waitrequest  input  1  downstream stall.
- s_readdata  input  DATA_W  downstream data; valid the cycle after a read is accepted.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - reset is synchronous and active-high. Its effect is only at the clk edge.
- Reset values:
  - state = IDLE, owner = 0, last_grant = 1 (so m0 wins the first contention).
  - s_read = s_write = 0.
  - mN_readdatavalid = 0, mN_readdata = 0.
  - mN_waitrequest = 1 while any request is pending.
- Request definition: master N requests when mN_read | mN_write. If both are high, the transaction is a write.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - s_read = s_write = 0.
  - If exactly one master requests, owner = that master.
  - If both request: with ROUND_ROBIN=1, owner = !last_grant; with ROUND_ROBIN=0, owner = 0.
  - On any request, last_grant <= owner and the next state is ISSUE.
  - No request: stay in IDLE.
- ISSUE:
  - s_address, s_writedata, s_byteenable, s_read and s_write are driven combinationally from the owner's inputs.
  - The owner's waitrequest = s_waitrequest. The non-owner's waitrequest = 1 if it is requesting.
  - Accept when s_waitrequest = 0. A write goes to IDLE; a read goes to RESP.
  - If s_waitrequest = 1, stay in ISSUE indefinitely. The owner must hold its inputs stable.
  - If the owner drops both read and write while in ISSUE, return to IDLE without a downstream strobe.
- RESP:
  - s_read = s_write = 0.
  - Register s_readdata into mOWNER_readdata and pulse mOWNER_readdatavalid for exactly one cycle, on the cycle after RESP.
  - Next state is IDLE.
  - The non-owner's readdata is never modified.
- Latency with no stalls:
  - Read: request visible in cycle 0 → ISSUE in cycle 1 (waitrequest low, accepted) → RESP in cycle 2 → readdatavalid in cycle 3.
  - Write: accepted in cycle 1.
  - Back-to-back throughput is one write per 2 cycles or one read per 3 cycles.
- Both masters held requesting with ROUND_ROBIN=1: grants strictly alternate 0,1,0,1…
- A master whose request arrives while the other owns the bus keeps waitrequest = 1 until it is granted and accepted. There is no request queueing inside the block.
- mN_readdata holds its last value between pulses.
- Reset mid-operation:
  - A reset during ISSUE or RESP aborts the transaction: no readdatavalid pulse, and the FSM is in IDLE at the next edge.
  - A downstream strobe may have been issued in the reset cycle. It is not replayed.
- s_address passes through unmodified; the arbiter does no address decoding.

Test Plan:
- m0 read at 0xBFC00000 alone, memory returns 0x3C08BFC0, waitrequest tied 0 → s_read high in cycle 1 only; m0_readdatavalid pulses in cycle 3 with m0_readdata=0x3C08BFC0; m1 outputs unchanged.
- m1 write to 0xBFC0002C, data 0xF0000000, byteenable 4'b1111 → single s_write cycle with matching fields; m1_waitrequest low for exactly that cycle; memory word 11 = 0xF0000000.
- m0 and m1 both read continuously from cycle 0, ROUND_ROBIN=1 → grant order m0,m1,m0,m1; readdatavalid pulses alternate every 3 cycles; each master receives only its own data.
- Same contention as above with ROUND_ROBIN=0 → m0 granted every time; m1_waitrequest stays 1 throughout.
- s_waitrequest held 1 for 5 cycles during an m1 read of 0xBFC00030 → s_read and address stable for 6 cycles; m1_readdatavalid pulses 2 cycles after s_waitrequest falls, with data 0x00000008.
- reset asserted in the RESP cycle of an m0 read → no m0_readdatavalid pulse; next cycle is IDLE with s_read=0; the next contended grant goes to m0.
